fork_join_collector: RTL and testbench
======================================

FORK_JOIN_COLLECTOR -- requirements
Module: fork_join_collector

Interface
REQ-001 SHALL have parameter N_CHILD, default 3, meaning the number of child workers (2..16).
REQ-002 SHALL have parameter TMO_W, default 8, meaning the width of the timeout counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port fork_req, input, 1 bit: parent requests a fork; level, sampled in IDLE only.
REQ-006 SHALL have port join_mode, input, 2 bits: 00 join-all, 01 join-any, 10 join-none, 11 treated as join-all; captured with fork_req.
REQ-007 SHALL have port tmo_cycles, input, TMO_W bits: timeout limit; 0 disables; captured with fork_req.
REQ-008 SHALL have port child_done, input, N_CHILD bits: per-child one-cycle completion event.
REQ-009 SHALL have port fork_ack, output, 1 bit: one-cycle pulse when fork_req is accepted.
REQ-010 SHALL have port child_start, output, N_CHILD bits: one-cycle start pulse to all children.
REQ-011 SHALL have port parent_go, output, 1 bit: one-cycle pulse releasing the parent.
REQ-012 SHALL have port all_done, output, 1 bit: one-cycle pulse when every child has completed (wait-fork).
REQ-013 SHALL have port done_mask, output, N_CHILD bits: sticky per-child completion since the last fork.
REQ-014 SHALL have port first_id, output, $clog2(N_CHILD) bits: index of the first child to complete.
REQ-015 SHALL have port timeout, output, 1 bit: one-cycle pulse on timeout expiry.
REQ-016 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, FORK, WAIT and DRAIN; all outputs registered.
REQ-018 IDLE with fork_req=1 SHALL pulse fork_ack, latch join_mode and tmo_cycles, clear done_mask and the timeout counter, and go to FORK.
REQ-019 FORK SHALL last exactly one cycle with child_start all-ones; in join-none, parent_go SHALL pulse in this same cycle and the next state SHALL be DRAIN; otherwise the next state SHALL be WAIT.
REQ-020 In WAIT and DRAIN, done_mask SHALL OR in child_done every cycle; child_done SHALL be ignored in IDLE and FORK.
REQ-021 Join-any: on the first WAIT cycle with any child_done bit set, first_id SHALL take the lowest set index, and parent_go SHALL pulse the following cycle; the next state SHALL be DRAIN, or IDLE with all_done if the mask is then complete.
REQ-022 Join-all: when done_mask|child_done becomes all-ones in WAIT, parent_go and all_done SHALL pulse together the following cycle, and the next state SHALL be IDLE.
REQ-023 DRAIN: when the mask becomes complete, all_done SHALL pulse the following cycle and the next state SHALL be IDLE; parent_go SHALL NOT pulse again.
REQ-024 A repeated done from an already-completed child SHALL have no effect; simultaneous dones SHALL all be recorded in the same cycle.
REQ-025 The timeout counter SHALL increment each WAIT or DRAIN cycle; when it reaches a nonzero tmo_cycles without completion, timeout SHALL pulse, parent_go SHALL also pulse if it has not yet been issued, and the next state SHALL be IDLE with done_mask retained.
REQ-026 Completion and timeout expiry in the same cycle SHALL resolve as completion; timeout SHALL NOT pulse.
REQ-027 fork_req in any state other than IDLE SHALL be ignored, with no fork_ack.
REQ-028 done_mask and first_id SHALL hold their values in IDLE until the next accepted fork.

Reset
REQ-029 rst_n low SHALL immediately force IDLE and drive every output to 0, regardless of the current state.
REQ-030 Reset mid-operation SHALL discard the latched mode, mask and counter; no output pulse SHALL be emitted while reset is asserted or on its release.

Verification
REQ-031 N=3, join-all: fork_req, then dones for children 2, 0, 1 on separate cycles -> parent_go and all_done pulse together one cycle after child 1's done; done_mask=111.
REQ-032 Join-any: child_done=110 sampled in a single cycle -> first_id=1, parent_go pulses the next cycle, state DRAIN; child 0 done later -> all_done pulses, busy falls.
REQ-033 Join-none: fork_req -> parent_go and child_start=111 pulse in the same cycle; parent_go does not pulse again; all_done pulses after the third done.
REQ-034 tmo_cycles=4, join-all, only child 0 completes -> timeout and parent_go pulse after 4 WAIT cycles; state IDLE; done_mask=001.
REQ-035 rst_n asserted in DRAIN with done_mask=011 -> all outputs 0 at once; a late child_done while in IDLE is ignored; the next fork behaves normally.
REQ-036 fork_req held high during WAIT -> no second fork_ack; after return to IDLE a new fork is accepted on the next cycle.

Source files
------------

// File: rtl/fork_join_collector.sv
// Fork/join collector: launches N_CHILD workers, tracks their completion
// and releases the parent according to a join-all / join-any / join-none policy,
// with an optional timeout.
module fork_join_collector #(
   parameter  int unsigned N_CHILD = 3,
   parameter  int unsigned TMO_W   = 8,
   localparam int unsigned ID_W    = $clog2(N_CHILD)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               fork_req,
   input  logic [1:0]         join_mode,
   input  logic [TMO_W-1:0]   tmo_cycles,
   input  logic [N_CHILD-1:0] child_done,
   output logic               fork_ack,
   output logic [N_CHILD-1:0] child_start,
   output logic               parent_go,
   output logic               all_done,
   output logic [N_CHILD-1:0] done_mask,
   output logic [ID_W-1:0]    first_id,
   output logic               timeout,
   output logic               busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FORK  = 2'd1,
      S_WAIT  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   localparam logic [1:0] M_ALL  = 2'b00;
   localparam logic [1:0] M_ANY  = 2'b01;
   localparam logic [1:0] M_NONE = 2'b10;

   state_t             state_q, state_d;
   logic [1:0]         mode_q, mode_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic [TMO_W-1:0]   cnt_q, cnt_d;
   logic [N_CHILD-1:0] mask_q, mask_d;
   logic [ID_W-1:0]    first_id_q, first_id_d;
   logic               fork_ack_q, fork_ack_d;
   logic [N_CHILD-1:0] child_start_q, child_start_d;
   logic               parent_go_q, parent_go_d;
   logic               all_done_q, all_done_d;
   logic               timeout_q, timeout_d;
   logic               busy_q, busy_d;
   logic               complete_c;
   logic               expire_c;

   // Lowest-index set bit of a completion vector.
   function automatic logic [ID_W-1:0] lowest_idx(input logic [N_CHILD-1:0] v);
      lowest_idx = '0;
      for (int i = int'(N_CHILD) - 1; i >= 0; i--) begin
         if (v[i]) lowest_idx = ID_W'(i);
      end
   endfunction

   // Next-state, bookkeeping and registered-output computation.
   always_comb begin
      state_d       = state_q;
      mode_d        = mode_q;
      tmo_d         = tmo_q;
      cnt_d         = cnt_q;
      mask_d        = mask_q;
      first_id_d    = first_id_q;
      fork_ack_d    = 1'b0;
      child_start_d = '0;
      parent_go_d   = 1'b0;
      all_done_d    = 1'b0;
      timeout_d     = 1'b0;
      complete_c    = 1'b0;
      expire_c      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (fork_req) begin
               fork_ack_d    = 1'b1;
               child_start_d = '1;
               mode_d        = (join_mode == 2'b11) ? M_ALL : join_mode;
               tmo_d         = tmo_cycles;
               cnt_d         = '0;
               mask_d        = '0;
               first_id_d    = '0;
               parent_go_d   = (join_mode == M_NONE);
               state_d       = S_FORK;
            end
         end

         S_FORK: begin
            state_d = (mode_q == M_NONE) ? S_DRAIN : S_WAIT;
         end

         S_WAIT, S_DRAIN: begin
            mask_d     = mask_q | child_done;
            cnt_d      = cnt_q + TMO_W'(1);
            complete_c = &mask_d;
            expire_c   = (tmo_q != '0) && (cnt_d == tmo_q);
            if ((mask_q == '0) && (child_done != '0)) begin
               first_id_d = lowest_idx(child_done);
            end
            // Completion wins over a coincident timeout.
            if (complete_c) begin
               all_done_d  = 1'b1;
               parent_go_d = (state_q == S_WAIT);
               state_d     = S_IDLE;
            end else if (expire_c) begin
               timeout_d   = 1'b1;
               parent_go_d = (state_q == S_WAIT);
               state_d     = S_IDLE;
            end else if ((state_q == S_WAIT) && (mode_q == M_ANY) && (child_done != '0)) begin
               parent_go_d = 1'b1;
               state_d     = S_DRAIN;
            end
         end

         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers; reset clears everything immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         mode_q        <= M_ALL;
         tmo_q         <= '0;
         cnt_q         <= '0;
         mask_q        <= '0;
         first_id_q    <= '0;
         fork_ack_q    <= 1'b0;
         child_start_q <= '0;
         parent_go_q   <= 1'b0;
         all_done_q    <= 1'b0;
         timeout_q     <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         mode_q        <= mode_d;
         tmo_q         <= tmo_d;
         cnt_q         <= cnt_d;
         mask_q        <= mask_d;
         first_id_q    <= first_id_d;
         fork_ack_q    <= fork_ack_d;
         child_start_q <= child_start_d;
         parent_go_q   <= parent_go_d;
         all_done_q    <= all_done_d;
         timeout_q     <= timeout_d;
         busy_q        <= busy_d;
      end
   end

   assign fork_ack    = fork_ack_q;
   assign child_start = child_start_q;
   assign parent_go   = parent_go_q;
   assign all_done    = all_done_q;
   assign done_mask   = mask_q;
   assign first_id    = first_id_q;
   assign timeout     = timeout_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_fork_join_collector.sv
// Bench for fork_join_collector: directed scenarios plus randomized
// transactions checked against a transaction-level model.
module tb_fork_join_collector;

   localparam int unsigned N     = 3;
   localparam int unsigned TW    = 8;
   localparam int unsigned IW    = 2;
   localparam int          NOEV  = 999;

   logic          clk;
   logic          rst_n;
   logic          fork_req;
   logic [1:0]    join_mode;
   logic [TW-1:0] tmo_cycles;
   logic [N-1:0]  child_done;
   logic          fork_ack;
   logic [N-1:0]  child_start;
   logic          parent_go;
   logic          all_done;
   logic [N-1:0]  done_mask;
   logic [IW-1:0] first_id;
   logic          timeout;
   logic          busy;

   int errors;
   int checks;

   // Per-cycle child_done schedule; index j is the j-th WAIT/DRAIN cycle.
   logic [N-1:0] vec_a [0:31];
   logic [N-1:0] cum_a [0:31];
   logic [N-1:0] hold_mask;
   int           hold_first;

   fork_join_collector #(.N_CHILD(N), .TMO_W(TW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fork_req    (fork_req),
      .join_mode   (join_mode),
      .tmo_cycles  (tmo_cycles),
      .child_done  (child_done),
      .fork_ack    (fork_ack),
      .child_start (child_start),
      .parent_go   (parent_go),
      .all_done    (all_done),
      .done_mask   (done_mask),
      .first_id    (first_id),
      .timeout     (timeout),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int low_idx(input logic [N-1:0] v);
      for (int i = 0; i < int'(N); i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, " fork_ack"},    32'(fork_ack),    32'd0);
      chk({tag, " child_start"}, 32'(child_start), 32'd0);
      chk({tag, " parent_go"},   32'(parent_go),   32'd0);
      chk({tag, " all_done"},    32'(all_done),    32'd0);
      chk({tag, " done_mask"},   32'(done_mask),   32'd0);
      chk({tag, " first_id"},    32'(first_id),    32'd0);
      chk({tag, " timeout"},     32'(timeout),     32'd0);
      chk({tag, " busy"},        32'(busy),        32'd0);
   endtask

   // Random schedule: each child completes once within L cycles, plus stray repeats.
   task automatic gen_vec();
      int len;
      len = $urandom_range(1, 12);
      for (int j = 0; j < 32; j++) vec_a[j] = '0;
      for (int i = 0; i < int'(N); i++) vec_a[$urandom_range(1, len)][i] = 1'b1;
      for (int j = 1; j <= len; j++) begin
         if ($urandom_range(0, 3) == 0) vec_a[j] = vec_a[j] | N'($urandom);
      end
   endtask

   task automatic clear_vec();
      for (int j = 0; j < 32; j++) vec_a[j] = '0;
   endtask

   // Idle cycles: no pulses, results held, stray dones ignored.
   task automatic idle(input int k);
      for (int n = 0; n < k; n++) begin
         @(posedge clk); #1;
         chk("idle busy",      32'(busy),      32'd0);
         chk("idle parent_go", 32'(parent_go), 32'd0);
         chk("idle all_done",  32'(all_done),  32'd0);
         chk("idle timeout",   32'(timeout),   32'd0);
         chk("idle fork_ack",  32'(fork_ack),  32'd0);
         chk("idle done_mask", 32'(done_mask), 32'(hold_mask));
         chk("idle first_id",  32'(first_id),  32'(hold_first));
         fork_req   = 1'b0;
         child_done = N'($urandom);
      end
   endtask

   // One fork transaction, called from an IDLE cycle. abort_c >= 0 asserts
   // reset in that cycle instead of finishing the transaction.
   task automatic run_txn(input logic [1:0] mode, input int tmo, input int abort_c);
      logic [1:0] eff;
      int comp, first, tj, end_c, pg_c, ad_c, to_c, fid, exp_fid;
      bit completed;
      eff = (mode == 2'b11) ? 2'b00 : mode;
      cum_a[0] = '0;
      comp  = NOEV;
      first = NOEV;
      for (int j = 1; j < 32; j++) begin
         cum_a[j] = cum_a[j-1] | vec_a[j];
         if (comp == NOEV && cum_a[j] == '1) comp = j;
         if (first == NOEV && vec_a[j] != '0) first = j;
      end
      tj = (tmo == 0) ? NOEV : tmo;
      completed = (comp <= tj);
      end_c = completed ? comp : tj;
      if (end_c > 30) begin
         chk("model schedule bound", 32'(end_c), 32'd30);
         return;
      end
      if (eff == 2'b10)      pg_c = 0;
      else if (eff == 2'b01) pg_c = ((first <= end_c) ? first : end_c) + 1;
      else                   pg_c = end_c + 1;
      ad_c = completed ? end_c + 1 : -1;
      to_c = completed ? -1 : end_c + 1;
      fid  = (first <= end_c) ? low_idx(vec_a[first]) : 0;

      fork_req   = 1'b1;
      join_mode  = mode;
      tmo_cycles = TW'(tmo);
      child_done = N'($urandom);
      for (int c = 0; c <= end_c + 1; c++) begin
         @(posedge clk); #1;
         exp_fid = (first <= end_c && c > first) ? fid : 0;
         chk($sformatf("fork_ack c%0d", c),    32'(fork_ack),    32'(c == 0));
         chk($sformatf("child_start c%0d", c), 32'(child_start), (c == 0) ? 32'(N'('1)) : 32'd0);
         chk($sformatf("parent_go c%0d", c),   32'(parent_go),   32'(c == pg_c));
         chk($sformatf("all_done c%0d", c),    32'(all_done),    32'(c == ad_c));
         chk($sformatf("timeout c%0d", c),     32'(timeout),     32'(c == to_c));
         chk($sformatf("busy c%0d", c),        32'(busy),        32'(c <= end_c));
         chk($sformatf("done_mask c%0d", c),   32'(done_mask),   (c == 0) ? 32'd0 : 32'(cum_a[c-1]));
         chk($sformatf("first_id c%0d", c),    32'(first_id),    32'(exp_fid));
         if (c == abort_c) begin
            rst_n = 1'b0;
            #1;
            chk_all_zero("reset asserted");
            fork_req   = 1'b1;
            child_done = N'($urandom);
            @(posedge clk); #1;
            chk_all_zero("reset held");
            fork_req   = 1'b0;
            rst_n      = 1'b1;
            child_done = 3'b001;
            @(posedge clk); #1;
            chk_all_zero("after release");
            hold_mask  = '0;
            hold_first = 0;
            return;
         end
         fork_req   = (c <= end_c) ? 1'($urandom) : 1'b0;
         child_done = (c >= 1 && c <= end_c) ? vec_a[c] : N'($urandom);
      end
      hold_mask  = cum_a[end_c];
      hold_first = (first <= end_c) ? fid : 0;
   endtask

   initial begin
      logic [1:0] m;
      int t;
      errors     = 0;
      checks     = 0;
      hold_mask  = '0;
      hold_first = 0;
      rst_n      = 1'b1;
      fork_req   = 1'b0;
      join_mode  = 2'b00;
      tmo_cycles = '0;
      child_done = '0;
      #2 rst_n = 1'b0;
      #1 chk_all_zero("power-on reset");
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);

      // Join-all, dones for children 2, 0, 1 on separate cycles.
      clear_vec(); vec_a[1] = 3'b100; vec_a[2] = 3'b001; vec_a[3] = 3'b010;
      run_txn(2'b00, 0, -1);
      idle(1);

      // Join-any, simultaneous dones 110 then child 0 later.
      clear_vec(); vec_a[2] = 3'b110; vec_a[4] = 3'b001;
      run_txn(2'b01, 0, -1);

      // Join-none back-to-back with the previous transaction.
      clear_vec(); vec_a[1] = 3'b001; vec_a[3] = 3'b010; vec_a[5] = 3'b100;
      run_txn(2'b10, 0, -1);
      idle(2);

      // Timeout of 4 with only child 0 completing.
      clear_vec(); vec_a[1] = 3'b001;
      run_txn(2'b00, 4, -1);
      idle(2);

      // Reset in DRAIN with mask 011, then a normal fork.
      clear_vec(); vec_a[1] = 3'b011; vec_a[3] = 3'b100;
      run_txn(2'b01, 0, 2);
      clear_vec(); vec_a[2] = 3'b111;
      run_txn(2'b11, 0, -1);
      idle(1);

      // Join-any with all children done at once.
      clear_vec(); vec_a[3] = 3'b111;
      run_txn(2'b01, 0, -1);
      idle(1);

      // Randomized transactions.
      for (int k = 0; k < 200; k++) begin
         gen_vec();
         m = 2'($urandom_range(0, 3));
         t = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 15);
         run_txn(m, t, -1);
         if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
